// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and EX operand forwarding.
// Define IDEX_PERF_CNT_EN to add the stall_cnt/flush_cnt event counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [2:0]    id_alu_ctrl,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt,
`endif
    output logic          ex_valid
);
    logic [RW-1:0] rs_q, rt_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
    logic          alu_src_q, bubble;

    assign stall  = ex_valid & ex_mem_read & (rt_q != '0) & ((rt_q == id_rs) | (rt_q == id_rt));
    assign bubble = flush | stall;

    // a bubble clears the whole stage so nothing stale leaks into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_ctrl      <= 3'b000;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_valid      <= 1'b0;
        end else begin
            rs_q          <= bubble ? '0 : id_rs;
            rt_q          <= bubble ? '0 : id_rt;
            rs_data_q     <= bubble ? '0 : id_rs_data;
            rt_data_q     <= bubble ? '0 : id_rt_data;
            imm_q         <= bubble ? '0 : id_imm;
            alu_src_q     <= bubble ? 1'b0 : id_alu_src;
            alu_ctrl      <= bubble ? 3'b000 : id_alu_ctrl;
            ex_dest       <= bubble ? '0 : (id_reg_dst ? id_rd : id_rt);
            ex_reg_write  <= bubble ? 1'b0 : id_reg_write;
            ex_mem_read   <= bubble ? 1'b0 : id_mem_read;
            ex_mem_write  <= bubble ? 1'b0 : id_mem_write;
            ex_mem_to_reg <= bubble ? 1'b0 : id_mem_to_reg;
            ex_valid      <= !bubble;
        end
    end

    always_comb begin
        fwd_rs = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q) ? exmem_result :
                 (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q) ? memwb_result : rs_data_q;
        fwd_rt = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q) ? exmem_result :
                 (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q) ? memwb_result : rt_data_q;
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

`ifdef IDEX_PERF_CNT_EN
    // flush takes precedence, so a simultaneous stall is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage against a behavioural pipeline-stage model.
module tb_id_ex_stage;
    logic        clk, rst_n;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush, exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_ctrl;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
`ifdef IDEX_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .ex_valid(ex_valid)
    );

    // first edge is a negedge so each pushed expectation is popped before the next capture
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, src;
        logic [2:0]  ctrl;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
    } ex_t;

    typedef struct packed {
        logic        stall, valid, rw, mr, mw, m2r;
        logic [2:0]  ctrl;
        logic [4:0]  dest;
        logic [31:0] a, b, sd, sc, fc;
    } exp_t;

    ex_t         m;
    exp_t        q[$];
    int unsigned m_sc, m_fc;
    int          checks, passed;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    function automatic logic model_stall();
        return m.valid && m.mr && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    endtask

    task automatic model_reset();
        m = '0;
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic cycle();
        exp_t e;
        logic st;
        st      = model_stall();
        e       = '0;
        e.stall = st;
        e.valid = m.valid;
        e.rw    = m.rw;
        e.mr    = m.mr;
        e.mw    = m.mw;
        e.m2r   = m.m2r;
        e.ctrl  = m.ctrl;
        e.dest  = m.dest;
        e.a     = fwd(m.rs, m.rsd);
        e.b     = m.src ? m.imm : fwd(m.rt, m.rtd);
        e.sd    = fwd(m.rt, m.rtd);
        e.sc    = m_sc;
        e.fc    = m_fc;
        q.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (flush) m_fc++;
            else if (st) m_sc++;
            if (flush || st) m = '0;
            else m = '{valid: 1'b1, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                       m2r: id_mem_to_reg, src: id_alu_src, ctrl: id_alu_ctrl, rs: id_rs,
                       rt: id_rt, dest: id_reg_dst ? id_rd : id_rt, rsd: id_rs_data,
                       rtd: id_rt_data, imm: id_imm};
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", {31'd0, stall}, {31'd0, e.stall});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("ctrl_bits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                {28'd0, e.rw, e.mr, e.mw, e.m2r});
            chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, e.ctrl});
            if (e.valid) begin
                chk("ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("store_data", ex_store_data, e.sd);
            end
`ifdef IDEX_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
`endif
        end
    end

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [2:0] ctrl, input logic src, input logic dst,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_ctrl = ctrl; id_alu_src = src; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic randomize_inputs();
        set_id(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)),
               $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom,
               3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
        flush           = $urandom_range(0, 7) == 0;
        exmem_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 9));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd        = 5'($urandom_range(0, 9));
        memwb_result    = $urandom;
    endtask

    initial begin
        int unsigned sc0, fc0;
        checks = 0;
        passed = 0;
        model_reset();
        rst_n = 0;
        flush = 0;
        clear_fwd();
        set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_valid_stall", {30'd0, ex_valid, stall}, 0);
        cycle();
        rst_n = 1;

        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("first_alu_a", alu_a, 5);
        chk("first_alu_b", alu_b, 7);
        chk("first_valid", {31'd0, ex_valid}, 1);

        set_id(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBEEF;
        #1 chk("exmem_priority", alu_a, 32'hDEAD);
        clear_fwd();

        set_id(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(5'd8, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("loaduse_stall", {31'd0, stall}, 1);
        cycle();
        chk("bubble_valid", {31'd0, ex_valid}, 0);
        chk("bubble_stall", {31'd0, stall}, 0);
        cycle();
        chk("replay_valid", {31'd0, ex_valid}, 1);

        set_id(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        set_id(5'd8, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1;
        sc0 = m_sc;
        fc0 = m_fc;
        #1 chk("flush_stall_both", {31'd0, stall}, 1);
        cycle();
        flush = 0;
        chk("flush_bubble", {31'd0, ex_valid}, 0);
`ifdef IDEX_PERF_CNT_EN
        chk("flush_cnt_inc", flush_cnt, fc0 + 1);
        chk("stall_cnt_hold", stall_cnt, sc0);
`endif

        set_id(5'd1, 5'd0, 5'd6, 32'h9, 32'h0, 32'h0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h1234;
        #1 chk("reg_zero", alu_b, 0);
        clear_fwd();

        set_id(5'd1, 5'd4, 5'd0, 32'h9, 32'h44, 32'hFFFFFFFC, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hCAFE;
        #1 chk("imm_alu_b", alu_b, 32'hFFFFFFFC);
        chk("imm_store", ex_store_data, 32'hCAFE);
        cycle();

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i == 200) begin
                rst_n = 0;
                #1 model_reset();
                chk("midrst_stall", {31'd0, stall}, 0);
                cycle();
                rst_n = 1;
            end else begin
                cycle();
            end
        end
        flush = 0;
        clear_fwd();
        repeat (3) @(posedge clk);
        if (q.size() != 0) chk("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-operand front end that directly feeds the 32-bit ALU (A, B, ALUControl).
- Latches decoded instruction fields from ID.
- Inserts bubbles on load-use hazards and flushes on taken branches.
- Resolves EX/MEM and MEM/WB forwarding to produce the final ALU operands.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs_data  in  DW  register-file read data for rs
- id_rt_data  in  DW  register-file read data for rt
- id_imm  in  DW  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW each  register addresses
- id_alu_ctrl  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- id_alu_src  in  1  1 = B operand is immediate
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- flush  in  1  branch taken; squash the instruction entering EX
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB writeback value
- stall  out  1  combinational; hold PC and IF/ID
- alu_a, alu_b  out  DW  forwarded ALU operands
- alu_ctrl  out  3  registered ALU control
- ex_store_data  out  DW  forwarded rt value for stores
- ex_dest  out  RW  selected destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
- ex_valid  out  1  EX holds a real, non-bubble instruction

Behaviour:
- Reset: all pipeline registers cleared asynchronously on rst_n low. Every registered output = 0, ex_valid = 0, alu_ctrl = 000. Forwarded outputs therefore read 0 until the first capture.
- Latency: one clock from ID inputs to registered EX outputs. Forwarding muxes and stall are combinational on the current-cycle registered state.
- Hazard detection (combinational):
  - stall = ex_valid & ex_mem_read & (ex_rt_q != 0) & ((ex_rt_q == id_rs) | (ex_rt_q == id_rt)).
  - ex_rt_q is the latched rt address.
- Capture priority on each rising edge:
  - (1) flush = 1: load a bubble (all control bits 0, ex_valid 0, alu_ctrl 000). Flush overrides stall.
  - (2) stall = 1: load a bubble. The ID instruction is held upstream and re-presented next cycle.
  - (3) Otherwise: capture all id_* fields, ex_valid = 1.
- ex_dest = id_reg_dst ? id_rd : id_rt, selected at capture.
- Operand forwarding, per source s in {rs, rt}:
  - Priority 1: exmem_reg_write & exmem_rd != 0 & exmem_rd == s_q → exmem_result.
  - Priority 2: else memwb_reg_write & memwb_rd != 0 & memwb_rd == s_q → memwb_result.
  - Otherwise the latched register data.
  - EX/MEM always wins when both stages match.
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b = ex_alu_src_q ? imm_q : forwarded rt.
  - ex_store_data = forwarded rt, independent of alu_src.
- Register 0: never forwarded; the latched value is used.
- Bubbles: forwarding still computed but irrelevant, since all control bits are 0.
- Reset mid-operation: in-flight instruction discarded and stall deasserts immediately. After release, the first edge captures normally.

Optional Feature:
- IDEX_PERF_CNT_EN defined:
  - Adds outputs stall_cnt and flush_cnt, 32 bits each.
  - Each increments on every clock edge where its condition is asserted (flush counted when flush = 1 regardless of stall; stall counted only when flush = 0).
  - Counters wrap from FFFFFFFF to 0 and clear on rst_n.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with id inputs nonzero and rst_n low → all outputs 0, stall 0. After release, one edge captures id_rs_data = 5, id_rt_data = 7, ctrl 010 → alu_a = 5, alu_b = 7, ex_valid = 1.
- EX/MEM forward: latched rs = 3, exmem_reg_write = 1, exmem_rd = 3, exmem_result = 0xDEAD → alu_a = 0xDEAD. With memwb_rd = 3 also matching (value 0xBEEF) → still 0xDEAD.
- Load-use: EX holds lw with rt = 8; ID presents id_rs = 8 → stall = 1. Next edge ex_valid = 0 and controls 0. Re-presented instruction is captured on the following edge with stall = 0.
- Flush and stall together: flush = 1 with a load-use condition present → bubble captured. With IDEX_PERF_CNT_EN, flush_cnt += 1 and stall_cnt unchanged.
- Register-zero: exmem_rd = 0, exmem_reg_write = 1, latched rt = 0, rt data 0 → alu_b = 0, not exmem_result.
- Immediate path: id_alu_src = 1, imm = 0xFFFFFFFC, forwarding active on rt → alu_b = 0xFFFFFFFC and ex_store_data = forwarded value.
